// File: rtl/pulse_capture_pkg.sv
// Shared types and default sizing for the pulse-width capture block.
package pulse_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        DONE
    } state_e;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin plus rise/fall detection.
// Flops reset high so a pin held high through reset never looks like a rise.
module sync_edge
    import pulse_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            sig_d_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d_q;
    assign fall  = ~sig_s & sig_d_q;

endmodule

// File: rtl/pulse_capture.sv
// Measures the length of high pulses on an asynchronous pin in clk cycles and
// holds each result behind a valid/ack handshake until it is consumed.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             ack,
    output logic [WIDTH-1:0] width,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    logic sig_s;
    logic rise;
    logic fall;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_in(sig_in),
        .sig_s (sig_s),
        .rise  (rise),
        .fall  (fall)
    );

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             sat_d;
    logic             ovf_q;
    logic [WIDTH-1:0] width_q;
    logic             valid_q;
    logic             overflow_q;
    logic             busy_q;

    // Saturating increment: once the counter is full it holds and flags overflow.
    always_comb begin
        count_d = count_q;
        sat_d   = 1'b0;
        if (count_q == '1) begin
            sat_d = 1'b1;
        end else begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            width_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (rise) begin
                        state_q <= MEASURE;
                        count_q <= WIDTH'(1);
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (fall) begin
                        state_q    <= DONE;
                        width_q    <= count_q;
                        overflow_q <= ovf_q;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (sig_s) begin
                        count_q <= count_d;
                        if (sat_d) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Edges seen here are dropped; ARMED needs a fresh rise.
                    if (ack) begin
                        valid_q    <= 1'b0;
                        overflow_q <= 1'b0;
                        state_q    <= en ? ARMED : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign width    = width_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule
